// File: rtl/ydma_cfg_credit_arbiter.sv
// Arbitrates one leaf packet-injection channel between host config words and per-port credit returns.
// Optional per-class packet counters are built when YDMA_ARB_STATS_EN is defined.
module ydma_cfg_credit_arbiter #(
   parameter int PACKET_BITS     = 97,
   parameter int NUM_LEAF_BITS   = 6,
   parameter int NUM_PORT_BITS   = 4,
   parameter int PAYLOAD_BITS    = 64,
   parameter int NUM_OUT_PORTS   = 7,
   parameter int CREDIT_CNT_BITS = 4,
   parameter int MAX_CFG_BURST   = 4
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    cfg_valid,
   output logic                                    cfg_ready,
   input  logic [NUM_LEAF_BITS-1:0]                cfg_leaf,
   input  logic [NUM_PORT_BITS-1:0]                cfg_port,
   input  logic [PAYLOAD_BITS-1:0]                 cfg_payload,
   input  logic [NUM_OUT_PORTS-1:0]                credit_req,
   input  logic [NUM_LEAF_BITS*NUM_OUT_PORTS-1:0]  credit_leaf,
   output logic [PACKET_BITS-1:0]                  pkt_out,
   input  logic                                    pkt_ready,
   output logic [NUM_OUT_PORTS-1:0]                credit_overflow
`ifdef YDMA_ARB_STATS_EN
   ,
   output logic [31:0]                             cfg_pkt_cnt,
   output logic [31:0]                             credit_pkt_cnt
`endif
);

   localparam int PAD_BITS   = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS - PAYLOAD_BITS;
   localparam int PTR_BITS   = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
   localparam int BURST_BITS = $clog2(MAX_CFG_BURST + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CFG    = 2'd1,
      S_CREDIT = 2'd2
   } state_t;

   state_t                      state_r;
   state_t                      state_nx_s;
   logic [BURST_BITS-1:0]       burst_r;
   logic [BURST_BITS-1:0]       burst_nx_s;
   logic [PTR_BITS-1:0]         rr_ptr_r;
   logic [PTR_BITS-1:0]         winner_s;
   logic                        pend_s;
   logic [CREDIT_CNT_BITS-1:0]  cnt_r [NUM_OUT_PORTS];
   logic [NUM_OUT_PORTS-1:0]    dec_s;
   logic [NUM_OUT_PORTS-1:0]    overflow_r;
   logic [PACKET_BITS-1:0]      pkt_r;
   logic                        load_slot_s;
   logic                        grant_cfg_s;
   logic                        grant_credit_s;

   // Credit returns land on ports 9 and up so they never alias the config ports.
   function automatic logic [NUM_PORT_BITS-1:0] credit_port_f(input logic [PTR_BITS-1:0] idx);
      logic [31:0] sum_v;
      sum_v = 32'(idx) + 32'd9;
      return sum_v[NUM_PORT_BITS-1:0];
   endfunction

   assign load_slot_s = !pkt_r[PACKET_BITS-1] || pkt_ready;

   // Round-robin scan of non-zero credit counters starting at rr_ptr.
   always_comb begin
      logic [PTR_BITS-1:0] idx_v;
      logic                hit_v;
      idx_v    = '0;
      hit_v    = 1'b0;
      pend_s   = 1'b0;
      winner_s = '0;
      for (int k = 0; k < NUM_OUT_PORTS; k++) begin
         idx_v    = PTR_BITS'((int'(rr_ptr_r) + k) % NUM_OUT_PORTS);
         hit_v    = !pend_s && (cnt_r[idx_v] != '0);
         winner_s = hit_v ? idx_v : winner_s;
         pend_s   = pend_s | hit_v;
      end
   end

   // Slot arbitration; grants happen only in load slots and never while in reset.
   always_comb begin
      grant_cfg_s    = 1'b0;
      grant_credit_s = 1'b0;
      state_nx_s     = state_r;
      burst_nx_s     = burst_r;
      if (reset || !load_slot_s) begin
         state_nx_s = state_r;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (cfg_valid) begin
                  grant_cfg_s = 1'b1;
                  state_nx_s  = S_CFG;
                  burst_nx_s  = BURST_BITS'(1);
               end else if (pend_s) begin
                  grant_credit_s = 1'b1;
                  state_nx_s     = S_CREDIT;
               end else begin
                  state_nx_s = S_IDLE;
               end
            end
            S_CFG: begin
               if (cfg_valid && (!pend_s || (burst_r < BURST_BITS'(MAX_CFG_BURST)))) begin
                  grant_cfg_s = 1'b1;
                  burst_nx_s  = (burst_r == BURST_BITS'(MAX_CFG_BURST)) ? burst_r
                                                                       : burst_r + BURST_BITS'(1);
               end else if (pend_s) begin
                  grant_credit_s = 1'b1;
                  state_nx_s     = S_CREDIT;
                  burst_nx_s     = '0;
               end else begin
                  state_nx_s = S_IDLE;
                  burst_nx_s = '0;
               end
            end
            S_CREDIT: begin
               if (cfg_valid) begin
                  grant_cfg_s = 1'b1;
                  state_nx_s  = S_CFG;
                  burst_nx_s  = BURST_BITS'(1);
               end else if (pend_s) begin
                  grant_credit_s = 1'b1;
                  state_nx_s     = S_CREDIT;
               end else begin
                  state_nx_s = S_IDLE;
                  burst_nx_s = '0;
               end
            end
            default: begin
               state_nx_s = S_IDLE;
               burst_nx_s = '0;
            end
         endcase
      end
   end

   // Per-port decrement strobes for the granted credit.
   always_comb begin
      dec_s = '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
         dec_s[i] = grant_credit_s && (winner_s == PTR_BITS'(i));
      end
   end

   // FSM state, config burst length and round-robin pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= S_IDLE;
         burst_r  <= '0;
         rr_ptr_r <= '0;
      end else begin
         state_r <= state_nx_s;
         burst_r <= burst_nx_s;
         if (grant_credit_s) begin
            rr_ptr_r <= (winner_s == PTR_BITS'(NUM_OUT_PORTS - 1)) ? '0 : winner_s + PTR_BITS'(1);
         end else begin
            rr_ptr_r <= rr_ptr_r;
         end
      end
   end

   // Pending-credit counters with sticky saturation flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            cnt_r[i] <= '0;
         end
         overflow_r <= '0;
      end else begin
         for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (credit_req[i] && !dec_s[i]) begin
               if (cnt_r[i] == '1) begin
                  overflow_r[i] <= 1'b1;
               end else begin
                  cnt_r[i] <= cnt_r[i] + CREDIT_CNT_BITS'(1);
               end
            end else if (!credit_req[i] && dec_s[i]) begin
               cnt_r[i] <= cnt_r[i] - CREDIT_CNT_BITS'(1);
            end else begin
               cnt_r[i] <= cnt_r[i];
            end
         end
      end
   end

   // Output packet register: load on grant, clear on an empty slot, hold under backpressure.
   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_r <= '0;
      end else if (load_slot_s) begin
         if (grant_cfg_s) begin
            pkt_r <= {1'b1, cfg_leaf, cfg_port, {PAD_BITS{1'b0}}, cfg_payload};
         end else if (grant_credit_s) begin
            pkt_r <= {1'b1, credit_leaf[int'(winner_s)*NUM_LEAF_BITS +: NUM_LEAF_BITS],
                      credit_port_f(winner_s), {PAD_BITS{1'b0}}, PAYLOAD_BITS'(1)};
         end else begin
            pkt_r <= '0;
         end
      end else begin
         pkt_r <= pkt_r;
      end
   end

   assign cfg_ready       = grant_cfg_s;
   assign pkt_out         = pkt_r;
   assign credit_overflow = overflow_r;

`ifdef YDMA_ARB_STATS_EN
   logic        is_cfg_r;
   logic [31:0] cfg_cnt_r;
   logic [31:0] credit_cnt_r;

   // Packet-class flag follows pkt_out; handshakes bump the matching counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         is_cfg_r     <= 1'b0;
         cfg_cnt_r    <= 32'd0;
         credit_cnt_r <= 32'd0;
      end else begin
         if (load_slot_s) begin
            is_cfg_r <= grant_cfg_s;
         end else begin
            is_cfg_r <= is_cfg_r;
         end
         if (pkt_r[PACKET_BITS-1] && pkt_ready) begin
            if (is_cfg_r) begin
               cfg_cnt_r <= cfg_cnt_r + 32'd1;
            end else begin
               credit_cnt_r <= credit_cnt_r + 32'd1;
            end
         end else begin
            cfg_cnt_r <= cfg_cnt_r;
         end
      end
   end

   assign cfg_pkt_cnt    = cfg_cnt_r;
   assign credit_pkt_cnt = credit_cnt_r;
`endif

endmodule

// File: tb/tb_ydma_cfg_credit_arbiter.sv
// Scoreboard bench for ydma_cfg_credit_arbiter: directed stimulus pushes expected packets,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_ydma_cfg_credit_arbiter;

   localparam int PB  = 97;
   localparam int LB  = 6;
   localparam int PTB = 4;
   localparam int PLB = 64;
   localparam int NP  = 7;
   localparam int PAD = PB - 1 - LB - PTB - PLB;

   logic                clk = 1'b0;
   logic                reset;
   logic                cfg_valid;
   logic                cfg_ready;
   logic [LB-1:0]       cfg_leaf;
   logic [PTB-1:0]      cfg_port;
   logic [PLB-1:0]      cfg_payload;
   logic [NP-1:0]       credit_req;
   logic [LB*NP-1:0]    credit_leaf;
   logic [PB-1:0]       pkt_out;
   logic                pkt_ready;
   logic [NP-1:0]       credit_overflow;

   logic [PB-1:0]       exp_q [$];
   int                  n_cmp = 0;
   int                  n_bad = 0;

   ydma_cfg_credit_arbiter dut (
      .clk             (clk),
      .reset           (reset),
      .cfg_valid       (cfg_valid),
      .cfg_ready       (cfg_ready),
      .cfg_leaf        (cfg_leaf),
      .cfg_port        (cfg_port),
      .cfg_payload     (cfg_payload),
      .credit_req      (credit_req),
      .credit_leaf     (credit_leaf),
      .pkt_out         (pkt_out),
      .pkt_ready       (pkt_ready),
      .credit_overflow (credit_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   // Credit leaves are 10+i so each port's packet is distinguishable.
   function automatic logic [PB-1:0] cr_pkt(input int i);
      logic [LB-1:0]  leaf_v;
      logic [PTB-1:0] port_v;
      leaf_v = LB'(10 + i);
      port_v = PTB'(i + 9);
      return {1'b1, leaf_v, port_v, {PAD{1'b0}}, 64'd1};
   endfunction

   function automatic logic [PB-1:0] cfg_pkt(input logic [LB-1:0] l, input logic [PTB-1:0] p,
                                            input logic [PLB-1:0] d);
      return {1'b1, l, p, {PAD{1'b0}}, d};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk({name, "_drained"}, 128'(exp_q.size()), 128'd0);
      @(negedge clk);
      chk({name, "_idle"}, 128'(pkt_out), 128'd0);
      step();
   endtask

   task automatic issue_cfg(input logic [LB-1:0] l, input logic [PTB-1:0] p, input logic [PLB-1:0] d);
      cfg_valid   = 1'b1;
      cfg_leaf    = l;
      cfg_port    = p;
      cfg_payload = d;
      exp_q.push_back(cfg_pkt(l, p, d));
   endtask

   // Monitor: compare every presented packet against the scoreboard head.
   always @(negedge clk) begin
      if (!reset && pkt_out[PB-1] === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pkt: actual %h required none", pkt_out);
         end else if (pkt_ready) begin
            chk("pkt", 128'(pkt_out), 128'(exp_q.pop_front()));
         end else begin
            chk("pkt_hold", 128'(pkt_out), 128'(exp_q[0]));
         end
      end
   end

   initial begin
      reset       = 1'b1;
      cfg_valid   = 1'b1;
      credit_req  = 7'h7F;
      pkt_ready   = 1'b1;
      cfg_leaf    = 6'd0;
      cfg_port    = 4'd0;
      cfg_payload = 64'd0;
      for (int i = 0; i < NP; i++) credit_leaf[i*LB +: LB] = LB'(10 + i);

      // Reset held with active requests.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_cfg_ready", 128'(cfg_ready), 128'd0);
         chk("rst_pkt_out", 128'(pkt_out), 128'd0);
         step();
      end
      reset      = 1'b0;
      cfg_valid  = 1'b0;
      credit_req = 7'h00;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("post_rst_pkt_out", 128'(pkt_out), 128'd0);
         chk("post_rst_overflow", 128'(credit_overflow), 128'd0);
         step();
      end

      // Single config word.
      issue_cfg(6'd5, 4'd0, 64'h90A3_0000_0000_0000);
      @(negedge clk);
      chk("single_cfg_ready", 128'(cfg_ready), 128'd1);
      step();
      cfg_valid = 1'b0;
      @(negedge clk);
      chk("single_cfg_ready_drop", 128'(cfg_ready), 128'd0);
      step();
      drain("single");

      // Round-robin credits, then pointer wrap.
      credit_req = 7'b0000101;
      exp_q.push_back(cr_pkt(0));
      exp_q.push_back(cr_pkt(2));
      step();
      credit_req = 7'b0000000;
      drain("rr");
      credit_req = 7'b0000001;
      exp_q.push_back(cr_pkt(0));
      step();
      credit_req = 7'b0000000;
      drain("rr_wrap");

      // Config burst limit with a credit pending from cycle 0.
      for (int k = 0; k < 6; k++) begin
         cfg_valid   = 1'b1;
         cfg_leaf    = LB'(20 + k);
         cfg_port    = PTB'(k % 2);
         cfg_payload = 64'(100 + k);
         credit_req  = (k == 0) ? 7'b0001000 : 7'b0000000;
         if (k == 4) exp_q.push_back(cr_pkt(3));
         else exp_q.push_back(cfg_pkt(cfg_leaf, cfg_port, cfg_payload));
         @(negedge clk);
         chk("burst_cfg_ready", 128'(cfg_ready), (k == 4) ? 128'd0 : 128'd1);
         step();
      end
      cfg_valid = 1'b0;
      drain("burst");

      // Backpressure: held packet, credits accumulate, then drain.
      issue_cfg(6'd7, 4'd1, 64'hA5A5_0123_4567_89AB);
      step();
      pkt_ready   = 1'b0;
      cfg_payload = 64'hDEAD_BEEF_0000_0001;
      for (int k = 0; k < 5; k++) begin
         credit_req = (k < 3) ? 7'b0000010 : 7'b0000000;
         @(negedge clk);
         chk("bp_cfg_ready", 128'(cfg_ready), 128'd0);
         step();
      end
      pkt_ready  = 1'b1;
      cfg_valid  = 1'b0;
      credit_req = 7'b0000000;
      for (int k = 0; k < 3; k++) exp_q.push_back(cr_pkt(1));
      drain("bp");

      // Saturate to 15, then increment coinciding with a grant.
      issue_cfg(6'd33, 4'd0, 64'h1111);
      step();
      cfg_valid = 1'b0;
      pkt_ready = 1'b0;
      for (int k = 0; k < 15; k++) begin
         credit_req = 7'b0000100;
         @(negedge clk);
         chk("sat15_overflow", 128'(credit_overflow), 128'd0);
         step();
      end
      pkt_ready  = 1'b1;
      credit_req = 7'b0000100;
      for (int k = 0; k < 16; k++) exp_q.push_back(cr_pkt(2));
      step();
      credit_req = 7'b0000000;
      @(negedge clk);
      chk("simul_overflow", 128'(credit_overflow), 128'd0);
      step();
      drain("simul");
      chk("simul_overflow_after", 128'(credit_overflow), 128'd0);

      // 17 pulses: counter saturates, sticky overflow.
      issue_cfg(6'd34, 4'd1, 64'h2222);
      step();
      cfg_valid = 1'b0;
      pkt_ready = 1'b0;
      for (int k = 0; k < 17; k++) begin
         credit_req = 7'b0000100;
         @(negedge clk);
         chk("sat17_overflow", 128'(credit_overflow), (k >= 16) ? 128'h4 : 128'h0);
         step();
      end
      pkt_ready  = 1'b1;
      credit_req = 7'b0000000;
      for (int k = 0; k < 15; k++) exp_q.push_back(cr_pkt(2));
      drain("sat17");
      chk("overflow_sticky", 128'(credit_overflow), 128'h4);

      // Reset mid-packet drops held packet and pending credits.
      issue_cfg(6'd40, 4'd0, 64'h3333);
      step();
      cfg_valid = 1'b0;
      pkt_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         credit_req = 7'b1000001;
         step();
      end
      credit_req = 7'b0000000;
      reset      = 1'b1;
      exp_q.delete();
      step();
      step();
      reset     = 1'b0;
      pkt_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("midrst_pkt_out", 128'(pkt_out), 128'd0);
         chk("midrst_overflow", 128'(credit_overflow), 128'd0);
         step();
      end
      chk("final_queue", 128'(exp_q.size()), 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
